// File: rtl/vcr_pkg.sv
// Shared VCR definitions: register addresses, output-limit state encoding and default cap.
package vcr_pkg;

  localparam logic [7:0] VCR_ADDR_80 = 8'h80;
  localparam logic [7:0] VCR_ADDR_81 = 8'h81;
  localparam logic [7:0] VCR_ADDR_82 = 8'h82;
  localparam logic [7:0] VCR_ADDR_83 = 8'h83;
  localparam logic [7:0] VCR_ADDR_84 = 8'h84;
  localparam logic [7:0] VCR_ADDR_OUTPUT_LIMIT = 8'h85;
  localparam logic [7:0] VCR_ADDR_86 = 8'h86;
  localparam logic [7:0] VCR_ADDR_87 = 8'h87;
  localparam logic [7:0] VCR_ADDR_88 = 8'h88;
  localparam logic [7:0] VCR_ADDR_89 = 8'h89;
  localparam logic [7:0] VCR_ADDR_8A = 8'h8A;
  localparam logic [7:0] VCR_ADDR_8B = 8'h8B;
  localparam logic [7:0] VCR_ADDR_A1 = 8'hA1;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] SNAP_ENC   = 2'd1;
  localparam logic [1:0] OUTPUT_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    SNAP   = SNAP_ENC,
    OUTPUT = OUTPUT_ENC
  } limit_state_t;

  localparam int unsigned OUTPUT_LIMIT_MAX_DEFAULT = 32768;

endpackage

// File: rtl/limit_downcounter.sv
// Loadable down-counter holding the number of granted words still to be delivered.
module limit_downcounter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             IFCLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Clear beats load beats decrement; a decrement at zero is ignored so it never wraps.
  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/output_limit_ctrl.sv
// Output-limit sequencer: snapshots FIFO occupancy on a VCR registration and gates high-speed reads.
// Define OUTPUT_LIMIT_STATS_EN to build the saturating ignored-registration counter.
module output_limit_ctrl
  import vcr_pkg::*;
#(
  parameter int unsigned             COUNT_WIDTH = 16,
  parameter logic [COUNT_WIDTH-1:0] MAX_WORDS   = COUNT_WIDTH'(OUTPUT_LIMIT_MAX_DEFAULT)
) (
  input  logic                   IFCLK,
  input  logic                   RESET,
  input  logic                   output_mode_limit,
  input  logic                   reg_output_limit,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  input  logic                   hs_rd,
  output logic                   hs_rd_allow,
  output logic [COUNT_WIDTH-1:0] output_limit,
  output logic                   output_limit_not_done,
  output logic [7:0]             reg_ignored_cnt
);

  limit_state_t           state, next_state;
  logic [COUNT_WIDTH-1:0] snap_value;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   remaining_zero;
  logic                   cnt_clr, cnt_load, cnt_dec;
  logic                   consume;

  assign snap_value  = (fifo_count > MAX_WORDS) ? MAX_WORDS : fifo_count;
  assign hs_rd_allow = !output_mode_limit || ((state == OUTPUT) && !remaining_zero);
  assign consume     = hs_rd && hs_rd_allow;

  // OUTPUT is only ever entered with a nonzero grant and left on the last word or an abort.
  assign output_limit_not_done = (state == OUTPUT);

  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (reg_output_limit && output_mode_limit) next_state = SNAP;
      end
      SNAP: begin
        if (!output_mode_limit) begin
          next_state = IDLE;
          cnt_clr    = 1'b1;
        end else begin
          cnt_load   = 1'b1;
          next_state = (snap_value != '0) ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (!output_mode_limit) begin
          next_state = IDLE;
          cnt_clr    = 1'b1;
        end else if (consume) begin
          cnt_dec = 1'b1;
          if (remaining == COUNT_WIDTH'(1)) next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  // The published limit only moves in SNAP so VCR can read it back over several cycles.
  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      output_limit <= '0;
    end else if (cnt_load) begin
      output_limit <= snap_value;
    end
  end

  limit_downcounter #(
    .WIDTH (COUNT_WIDTH)
  ) u_remaining (
    .IFCLK      (IFCLK),
    .RESET      (RESET),
    .clr        (cnt_clr),
    .load       (cnt_load),
    .load_value (snap_value),
    .dec        (cnt_dec),
    .count      (remaining),
    .zero       (remaining_zero)
  );

`ifdef OUTPUT_LIMIT_STATS_EN
  logic [7:0] ignored_q;

  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      ignored_q <= 8'd0;
    end else if (reg_output_limit && output_mode_limit && (state != IDLE) && (ignored_q != 8'hFF)) begin
      ignored_q <= ignored_q + 8'd1;
    end
  end

  assign reg_ignored_cnt = ignored_q;
`else
  assign reg_ignored_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_output_limit_ctrl.sv
// Directed self-checking bench for output_limit_ctrl with hand-computed expectations.
module tb_output_limit_ctrl;

  logic        IFCLK = 1'b0;
  logic        RESET;
  logic        output_mode_limit;
  logic        reg_output_limit;
  logic [15:0] fifo_count;
  logic        hs_rd;
  logic        hs_rd_allow;
  logic [15:0] output_limit;
  logic        output_limit_not_done;
  logic [7:0]  reg_ignored_cnt;

  int testCount = 0;
  int failCount = 0;
  int accepted;

`ifdef OUTPUT_LIMIT_STATS_EN
  localparam int EXP_IGNORED = 3;
`else
  localparam int EXP_IGNORED = 0;
`endif

  output_limit_ctrl dut (
    .IFCLK                 (IFCLK),
    .RESET                 (RESET),
    .output_mode_limit     (output_mode_limit),
    .reg_output_limit      (reg_output_limit),
    .fifo_count            (fifo_count),
    .hs_rd                 (hs_rd),
    .hs_rd_allow           (hs_rd_allow),
    .output_limit          (output_limit),
    .output_limit_not_done (output_limit_not_done),
    .reg_ignored_cnt       (reg_ignored_cnt)
  );

  always #5 IFCLK = ~IFCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic pulse, input logic [15:0] count, input logic rd);
    output_mode_limit = mode;
    reg_output_limit  = pulse;
    fifo_count        = count;
    hs_rd             = rd;
  endtask

  task automatic tick();
    @(posedge IFCLK);
    #1;
  endtask

  // Returns one cycle after the pulse was sampled (DUT in SNAP).
  task automatic registerPulse();
    reg_output_limit = 1'b1;
    tick();
    reg_output_limit = 1'b0;
  endtask

  task automatic drainWords(input int n);
    hs_rd = 1'b1;
    repeat (n) tick();
    hs_rd = 1'b0;
  endtask

  // Counts words accepted with hs_rd held high until allow drops or the budget expires.
  task automatic drainAll(input int budget, output int count);
    count = 0;
    hs_rd = 1'b1;
    while (hs_rd_allow && (count < budget)) begin
      count++;
      tick();
    end
    hs_rd = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
    #12;
    checkOutput("reset_limit", 32'(output_limit), 32'd0);
    checkOutput("reset_not_done", 32'(output_limit_not_done), 32'd0);
    checkOutput("reset_ignored", 32'(reg_ignored_cnt), 32'd0);
    checkOutput("reset_allow_limit_mode", 32'(hs_rd_allow), 32'd0);
    output_mode_limit = 1'b0;
    #1;
    checkOutput("reset_allow_passthrough", 32'(hs_rd_allow), 32'd1);
    RESET = 1'b0;
    tick();

    // Normal grant of 100 words.
    applyStimulus(1'b1, 1'b0, 16'd100, 1'b0);
    tick();
    registerPulse();
    checkOutput("snap_not_done_low", 32'(output_limit_not_done), 32'd0);
    tick();
    checkOutput("g100_limit", 32'(output_limit), 32'd100);
    checkOutput("g100_not_done", 32'(output_limit_not_done), 32'd1);
    checkOutput("g100_allow", 32'(hs_rd_allow), 32'd1);
    drainWords(99);
    checkOutput("g100_not_done_after99", 32'(output_limit_not_done), 32'd1);
    checkOutput("g100_allow_after99", 32'(hs_rd_allow), 32'd1);
    drainWords(1);
    checkOutput("g100_not_done_after100", 32'(output_limit_not_done), 32'd0);
    checkOutput("g100_allow_after100", 32'(hs_rd_allow), 32'd0);
    drainWords(3);
    checkOutput("g100_allow_extra_rd", 32'(hs_rd_allow), 32'd0);
    checkOutput("g100_limit_retained", 32'(output_limit), 32'd100);

    // Occupancy above the cap.
    fifo_count = 16'd40000;
    registerPulse();
    tick();
    checkOutput("cap_limit", 32'(output_limit), 32'd32768);
    drainAll(40000, accepted);
    checkOutput("cap_drain_count", 32'(accepted), 32'd32768);
    checkOutput("cap_not_done_end", 32'(output_limit_not_done), 32'd0);

    // Empty grant, then an immediate re-registration two cycles later.
    fifo_count = 16'd0;
    registerPulse();
    checkOutput("empty_snap_not_done", 32'(output_limit_not_done), 32'd0);
    tick();
    checkOutput("empty_limit", 32'(output_limit), 32'd0);
    checkOutput("empty_not_done", 32'(output_limit_not_done), 32'd0);
    checkOutput("empty_allow", 32'(hs_rd_allow), 32'd0);
    fifo_count = 16'd7;
    registerPulse();
    tick();
    checkOutput("respace_limit", 32'(output_limit), 32'd7);
    checkOutput("respace_not_done", 32'(output_limit_not_done), 32'd1);
    checkOutput("respace_ignored", 32'(reg_ignored_cnt), 32'd0);
    drainAll(20, accepted);
    checkOutput("respace_drain_count", 32'(accepted), 32'd7);

    // Registrations while busy are ignored.
    fifo_count = 16'd60;
    registerPulse();
    tick();
    drainWords(10);
    fifo_count = 16'd5;
    repeat (3) begin
      registerPulse();
      tick();
    end
    checkOutput("busy_limit", 32'(output_limit), 32'd60);
    checkOutput("busy_ignored", 32'(reg_ignored_cnt), 32'(EXP_IGNORED));
    checkOutput("busy_not_done", 32'(output_limit_not_done), 32'd1);
    drainAll(100, accepted);
    checkOutput("busy_drain_count", 32'(accepted), 32'd50);

    // Registration in passthrough mode is dropped silently.
    output_mode_limit = 1'b0;
    registerPulse();
    tick();
    checkOutput("pass_limit", 32'(output_limit), 32'd60);
    checkOutput("pass_ignored", 32'(reg_ignored_cnt), 32'(EXP_IGNORED));
    checkOutput("pass_allow", 32'(hs_rd_allow), 32'd1);
    output_mode_limit = 1'b1;
    #1;
    checkOutput("pass_back_idle_allow", 32'(hs_rd_allow), 32'd0);

    // Abort by leaving limit mode mid-drain.
    fifo_count = 16'd20;
    registerPulse();
    tick();
    drainWords(5);
    output_mode_limit = 1'b0;
    tick();
    checkOutput("abort_not_done", 32'(output_limit_not_done), 32'd0);
    checkOutput("abort_allow", 32'(hs_rd_allow), 32'd1);
    checkOutput("abort_limit", 32'(output_limit), 32'd20);
    output_mode_limit = 1'b1;
    tick();
    checkOutput("abort_idle_allow", 32'(hs_rd_allow), 32'd0);

    // Asynchronous reset during OUTPUT with reads in flight.
    fifo_count = 16'd30;
    registerPulse();
    tick();
    hs_rd = 1'b1;
    repeat (3) tick();
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("areset_limit", 32'(output_limit), 32'd0);
    checkOutput("areset_not_done", 32'(output_limit_not_done), 32'd0);
    checkOutput("areset_ignored", 32'(reg_ignored_cnt), 32'd0);
    checkOutput("areset_allow", 32'(hs_rd_allow), 32'd0);
    tick();
    #2;
    RESET = 1'b0;
    repeat (3) tick();
    checkOutput("post_reset_allow", 32'(hs_rd_allow), 32'd0);
    checkOutput("post_reset_not_done", 32'(output_limit_not_done), 32'd0);
    hs_rd = 1'b0;
    fifo_count = 16'd4;
    registerPulse();
    tick();
    checkOutput("post_reset_limit", 32'(output_limit), 32'd4);
    drainAll(10, accepted);
    checkOutput("post_reset_drain", 32'(accepted), 32'd4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
